// File: rtl/nios_core_pio_in.sv
// nios_core_pio_in: Avalon-MM parallel input port with edge capture and irq.
// Optional macro PIO_DEBOUNCE_EN adds a per-bit debounce counter.
module nios_core_pio_in #(
    parameter int WIDTH           = 16,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_level_d;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_irqmask;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdmux;

    // two-flop synchroniser for the asynchronous inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt [WIDTH];

    // per-bit debounce: level follows sync2 only after it stays different long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    // without debounce, level is simply sync2 one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            r_level <= r_sync2;
        end
    end
`endif

    // delayed copy of level used as the edge-detect reference
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level_d <= '0;
        end else begin
            r_level_d <= r_level;
        end
    end

    // per-bit edge detect of the selected polarity
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = r_level & ~r_level_d;
            1:       w_edge = ~r_level & r_level_d;
            default: w_edge = r_level ^ r_level_d;
        endcase
    end

    // bus write decode and write-1-to-clear mask for edgecapture
    always_comb begin
        w_wr  = chipselect & ~write_n;
        w_clr = '0;
        if (w_wr && (address == 2'd3)) begin
            w_clr = writedata[WIDTH-1:0];
        end
    end

    // edgecapture: sticky set, cleared by write-1, set wins on collision
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    // interrupt mask register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_wr && (address == 2'd2)) begin
            r_irqmask <= writedata[WIDTH-1:0];
        end
    end

    // read mux, zero-extended to the bus width
    always_comb begin
        w_rdmux = '0;
        case (address)
            2'd0:    w_rdmux[WIDTH-1:0] = r_level;
            2'd2:    w_rdmux[WIDTH-1:0] = r_irqmask;
            2'd3:    w_rdmux[WIDTH-1:0] = r_edgecap;
            default: w_rdmux = '0;
        endcase
    end

    // registered read data, refreshed every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdmux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: doc/nios_core_pio_in.md
NIOS_CORE_PIO_IN -- requirements
Module: nios_core_pio_in

Interface
REQ-001 Parameter WIDTH, default 16: input port width, legal 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: capture edge, 0 = rising, 1 = falling, 2 = any.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: stable cycles needed before a bit is accepted, legal 2..65535; used only when PIO_DEBOUNCE_EN is defined.
REQ-004 Port clk, input, 1: sole clock; all logic on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port address, input, 2: Avalon-MM word address.
REQ-007 Port chipselect, input, 1: Avalon-MM select.
REQ-008 Port write_n, input, 1: Avalon-MM write strobe, active-low, qualified by chipselect.
REQ-009 Port writedata, input, 32: Avalon-MM write data.
REQ-010 Port in_port, input, WIDTH: asynchronous external inputs.
REQ-011 Port readdata, output, 32: registered Avalon-MM read data.
REQ-012 Port irq, output, 1: level interrupt request, active-high.

Function
REQ-013 in_port SHALL pass through a 2-flop synchroniser per bit (sync1, sync2) before any other use.
REQ-014 Filtered value "level" SHALL equal sync2 delayed 1 cycle when debounce is compiled out.
REQ-015 Register map: 0 = level (read-only); 1 = reserved, reads 0, writes ignored; 2 = irqmask (RW, WIDTH bits); 3 = edgecapture (read; write-1-to-clear).
REQ-016 readdata SHALL update every cycle with the mux of the current address, zero-extended to 32 bits; read latency is 1 cycle; chipselect is not required for reads.
REQ-017 A write occurs when chipselect = 1 and write_n = 0; only writedata[WIDTH-1:0] is used.
REQ-018 Edge detect SHALL compare level with its 1-cycle-delayed copy, level_d, per bit, using the type selected by EDGE_TYPE.
REQ-019 A detected edge SHALL set its edgecapture bit on the next clock; the bit holds until cleared.
REQ-020 A write to address 3 SHALL clear every edgecapture bit whose writedata bit is 1.
REQ-021 If an edge and a clear hit the same bit in the same cycle, the set SHALL win and the bit reads 1.
REQ-022 irq SHALL be |(edgecapture & irqmask), driven combinationally from registers only; there is no path from in_port to irq that bypasses registers.
REQ-023 Latency: an in_port change stable from cycle N SHALL be visible in level at N+3, in edgecapture at N+4, and on readdata at N+5 (debounce compiled out).
REQ-024 Bits at index WIDTH and above SHALL read 0 for all addresses.

Reset
REQ-025 While reset = 1 at a clock edge: sync1, sync2, level, level_d, edgecapture, irqmask, readdata and all debounce counters SHALL become 0; irq SHALL be 0.
REQ-026 No edge SHALL be captured on the first cycle after reset, even if in_port is high; level_d equals level until level changes.
REQ-027 Reset asserted mid-debounce or with an edge pending SHALL discard that state; nothing is captured after reset is released.

Configuration
REQ-028 Macro PIO_DEBOUNCE_EN, when defined, SHALL add a per-bit counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-029 Counter behaviour: reset to 0 whenever sync2 equals level; otherwise increment; when it reaches DEBOUNCE_CYCLES-1, level takes sync2 and the counter clears. Added latency is DEBOUNCE_CYCLES-1 cycles; glitches shorter than DEBOUNCE_CYCLES are rejected.
REQ-030 With PIO_DEBOUNCE_EN undefined, no counter logic SHALL be present, and behaviour follows REQ-014.

Verification
REQ-031 Reset, then read address 0 with in_port = 16'hA5C3 held 10 cycles -> readdata = 32'h0000A5C3; irq = 0.
REQ-032 EDGE_TYPE = 0, irqmask = 16'h0001, in_port[0] 0 -> 1 -> readdata at address 3 = 1, irq = 1; write 32'h1 to address 3 -> edgecapture = 0, irq = 0.
REQ-033 Clear of bit 0 issued in the same cycle the bit-0 edge is detected -> edgecapture[0] = 1 afterwards.
REQ-034 EDGE_TYPE = 2, irqmask = 0, toggle in_port[3] -> edgecapture = 16'h0008, irq stays 0; set irqmask = 16'h0008 -> irq = 1 next cycle.
REQ-035 PIO_DEBOUNCE_EN defined, DEBOUNCE_CYCLES = 4: 2-cycle pulse on in_port[1] -> level unchanged, no capture; 6-cycle pulse -> level[1] = 1, edgecapture[1] = 1.
REQ-036 Assert reset while edgecapture = 16'hFFFF and irqmask = 16'hFFFF -> every register 0, irq = 0, readdata = 0 on the next cycle.
